// File: rtl/memory_stage_pkg.sv
// Shared definitions for the pipeline memory stage: the 4-bit opcode
// space used by decode/execute/memory and the memory-stage state encoding.
package memory_stage_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'b0000,
        OP_ADD    = 4'b0001,
        OP_SUB    = 4'b0010,
        OP_AND    = 4'b0011,
        OP_OR     = 4'b0100,
        OP_XOR    = 4'b0101,
        OP_SHL    = 4'b0110,
        OP_SHR    = 4'b0111,
        OP_SRA    = 4'b1000,
        OP_SLT    = 4'b1001,
        OP_SLTU   = 4'b1010,
        OP_LUI    = 4'b1011,
        OP_LOAD   = 4'b1100,
        OP_BRANCH = 4'b1101,
        OP_STORE  = 4'b1110,
        OP_MOV    = 4'b1111
    } opcode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    // True for opcodes that need a data-memory transaction.
    function automatic logic is_mem_op(input logic [3:0] op);
        logic hit;
        case (op)
            OP_LOAD:  hit = 1'b1;
            OP_STORE: hit = 1'b1;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/memory_stage_timeout.sv
// mem_timeout_counter: counts consecutive ACCESS cycles and flags the
// cycle in which the LIMIT-th one is in progress. Used by memory_stage
// only when MEMORY_STAGE_TIMEOUT_EN is defined.
module mem_timeout_counter #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    output logic expired_o
);

    localparam logic [3:0] LAST_CNT = 4'(LIMIT - 1);

    logic [3:0] cnt_q;

    // Count ACCESS cycles; any IDLE cycle clears the count for the next op.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else if (active_i) begin
            if (cnt_q != 4'hF) begin
                cnt_q <= cnt_q + 4'd1;
            end else begin
                cnt_q <= cnt_q;
            end
        end else begin
            cnt_q <= 4'd0;
        end
    end

    // cnt_q holds the number of ACCESS cycles already completed.
    always_comb begin
        expired_o = active_i && (cnt_q == LAST_CNT);
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory-access stage. Non-memory ops retire with
// one cycle of latency; LOAD/STORE issue one registered request and wait
// in ACCESS (holding the upstream stall) until mem_ack.
// Optional feature macro: MEMORY_STAGE_TIMEOUT_EN adds an ACCESS timeout
// that aborts the request and sets the sticky mem_err flag.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        control_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic [4:0]        dest_index_in,
    input  logic              reg_write_en_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_index,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    mem_state_e        state_q;
    logic              op_store_q;
    logic [4:0]        dest_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              wb_valid_q;
    logic              wb_en_q;
    logic [4:0]        wb_index_q;
    logic [DATA_W-1:0] wb_data_q;

    logic [3:0]        op_s;
    logic              is_mem_s;
    logic              is_store_s;
    logic              timeout_s;
    logic              unused_s;

    // Opcode decode; bit 4 of control_in carries nothing for this stage.
    always_comb begin
        op_s       = control_in[3:0];
        is_mem_s   = is_mem_op(op_s);
        is_store_s = (op_s == OP_STORE);
        unused_s   = ^{control_in[4], 4'(TIMEOUT_CYC)};
    end

`ifdef MEMORY_STAGE_TIMEOUT_EN
    logic mem_err_q;

    mem_timeout_counter #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .active_i  (state_q == ST_ACCESS),
        .expired_o (timeout_s)
    );

    // Sticky timeout flag: set on an unacknowledged expiry, cleared by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_err_q <= 1'b0;
        end else if ((state_q == ST_ACCESS) && !mem_ack && timeout_s) begin
            mem_err_q <= 1'b1;
        end else begin
            mem_err_q <= mem_err_q;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign timeout_s = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Stage FSM with registered memory-request and writeback outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_store_q  <= 1'b0;
            dest_q      <= 5'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_index_q  <= 5'd0;
            wb_data_q   <= '0;
        end else begin
            // Writeback is a one-cycle pulse unless a retire below re-asserts it.
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_in && is_mem_s) begin
                        state_q     <= ST_ACCESS;
                        op_store_q  <= is_store_s;
                        dest_q      <= dest_index_in;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= is_store_s;
                        mem_addr_q  <= result_in;
                        mem_wdata_q <= is_store_s ? store_data_in : '0;
                    end else if (valid_in) begin
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= reg_write_en_in;
                        wb_index_q <= dest_index_in;
                        wb_data_q  <= result_in;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Ack is checked first so a late ack still completes normally.
                    if (mem_ack) begin
                        state_q    <= ST_IDLE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= !op_store_q;
                        wb_index_q <= dest_q;
                        wb_data_q  <= op_store_q ? mem_addr_q : mem_rdata;
                    end else if (timeout_s) begin
                        state_q    <= ST_IDLE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= 1'b0;
                        wb_index_q <= dest_q;
                        wb_data_q  <= mem_addr_q;
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = (state_q == ST_ACCESS);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_en     = wb_en_q;
    assign wb_index  = wb_index_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: retirements are predicted into a
// scoreboard queue when stimulus is driven and checked by a writeback monitor.
module tb_memory_stage;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    control_in = 5'd0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] result_in = 16'h0000;
    logic [DW-1:0] store_data_in = 16'h0000;
    logic [4:0]    dest_index_in = 5'd0;
    logic          reg_write_en_in = 1'b0;
    logic          stall, mem_req, mem_we, mem_ack = 1'b0;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata = 16'h0000;
    logic          wb_valid, wb_en, mem_err;
    logic [4:0]    wb_index;
    logic [DW-1:0] wb_data;

    typedef struct {
        logic          en;
        logic [4:0]    idx;
        logic [DW-1:0] data;
        bit            chk_idx;
        bit            chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    memory_stage #(.DATA_W(DW), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset(reset), .control_in(control_in), .valid_in(valid_in),
        .result_in(result_in), .store_data_in(store_data_in),
        .dest_index_in(dest_index_in), .reg_write_en_in(reg_write_en_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_index(wb_index),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Writeback monitor: every wb_valid pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (wb_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wb: got wb_valid=1 idx=%0d data=%h, required no retirement", wb_index, wb_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (wb_en !== e.en || (e.chk_idx && wb_index !== e.idx) || (e.chk_data && wb_data !== e.data)) begin
                        errors++;
                        $display("FAIL wb_retire: got en=%b idx=%0d data=%h, required en=%b idx=%0d data=%h",
                                 wb_en, wb_index, wb_data, e.en, e.idx, e.data);
                    end
                end
            end else if (wb_en !== 1'b0) begin
                errors++;
                $display("FAIL wb_en_idle: got wb_en=%b with wb_valid=%b, required 0", wb_en, wb_valid);
            end
        end
    end

    task automatic push_exp(input logic en, input logic [4:0] idx, input logic [DW-1:0] data,
                            input bit ci, input bit cd);
        exp_t e;
        e.en = en; e.idx = idx; e.data = data; e.chk_idx = ci; e.chk_data = cd;
        exp_q.push_back(e);
    endtask

    task automatic set_op(input logic [4:0] ctl, input logic [DW-1:0] res, input logic [DW-1:0] sd,
                          input logic [4:0] dst, input logic we);
        control_in = ctl; result_in = res; store_data_in = sd;
        dest_index_in = dst; reg_write_en_in = we; valid_in = 1'b1;
    endtask

    task automatic check_access(input string name, input logic [DW-1:0] addr, input logic we,
                                input logic [DW-1:0] wdata);
        checks++;
        if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== addr || mem_we !== we || mem_wdata !== wdata) begin
            errors++;
            $display("FAIL %s: got req=%b stall=%b addr=%h we=%b wdata=%h, required 1 1 %h %b %h",
                     name, mem_req, stall, mem_addr, mem_we, mem_wdata, addr, we, wdata);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s: got req=%b stall=%b, required 0 0", name, mem_req, stall);
        end
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_en, wb_index, wb_data, mem_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wb_valid=%b wb_data=%h err=%b stall=%b, required all 0",
                     mem_req, mem_we, mem_addr, wb_valid, wb_data, mem_err, stall);
        end
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_alu();
        logic [4:0]    ctl [5] = '{5'b00001, 5'b00010, 5'b01111, 5'b00000, 5'b10001};
        logic [DW-1:0] res [5] = '{16'h1234, 16'hFFFF, 16'h8001, 16'h0000, 16'h5A5A};
        logic [4:0]    dst [5] = '{5'd5, 5'd31, 5'd1, 5'd0, 5'd17};
        logic          we  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        // Single ADD: one-cycle latency.
        @(negedge clk);
        set_op(5'b00001, 16'h1234, 16'h0000, 5'd5, 1'b1);
        push_exp(1'b1, 5'd5, 16'h1234, 1'b1, 1'b1);
        @(negedge clk); valid_in = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL add_latency: got wb_valid=%b stall=%b, required 1 0", wb_valid, stall);
        end
        // Back-to-back non-memory ops, one per cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_op(ctl[i], res[i], 16'hDEAD, dst[i], we[i]);
            push_exp(we[i], dst[i], res[i], 1'b1, 1'b1);
        end
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        @(negedge clk);
        set_op(5'b01100, 16'h0040, 16'h7777, 5'd3, 1'b0);
        push_exp(1'b1, 5'd3, 16'hBEEF, 1'b1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_access("load_access", 16'h0040, 1'b0, 16'h0000);
            // A new op presented during ACCESS must be ignored.
            set_op(5'b00001, 16'h9999, 16'h0000, 5'd9, 1'b1);
            if (c == 3) begin
                mem_ack = 1'b1; mem_rdata = 16'hBEEF;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; valid_in = 1'b0; mem_rdata = 16'h0000;
        check_idle("load_done");
        // Ack while IDLE is ignored.
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        check_idle("ack_in_idle");
        @(negedge clk);
    endtask

    task automatic test_store();
        @(negedge clk);
        set_op(5'b01110, 16'h0010, 16'h00AA, 5'd7, 1'b1);
        push_exp(1'b0, 5'd7, 16'h0010, 1'b0, 1'b1);
        @(negedge clk); valid_in = 1'b0;
        check_access("store_access", 16'h0010, 1'b1, 16'h00AA);
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL store_retire: got wb_valid=%b req=%b we=%b, required 1 0 0", wb_valid, mem_req, mem_we);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_op(5'b01100, 16'h0100, 16'h0000, 5'd12, 1'b0);
        push_exp(1'b1, 5'd12, 16'hC0DE, 1'b1, 1'b1);
        @(negedge clk);
        check_access("b2b_access", 16'h0100, 1'b0, 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'hC0DE;
        set_op(5'b00011, 16'h0F0F, 16'h0000, 5'd20, 1'b1);
        @(negedge clk);
        mem_ack = 1'b0;
        check_idle("b2b_retire");
        // Held op is accepted only now, in the IDLE cycle after retirement.
        push_exp(1'b1, 5'd20, 16'h0F0F, 1'b1, 1'b1);
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        set_op(5'b01100, 16'h0200, 16'h0000, 5'd4, 1'b0);
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk);
        check_access("abort_access2", 16'h0200, 1'b0, 16'h0000);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_idle("abort_after_reset");
        @(negedge clk);
        set_op(5'b00001, 16'h4321, 16'h0000, 5'd8, 1'b1);
        push_exp(1'b1, 5'd8, 16'h4321, 1'b1, 1'b1);
        @(negedge clk); valid_in = 1'b0;
        @(negedge clk);
    endtask

`ifdef MEMORY_STAGE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        @(negedge clk);
        set_op(5'b01100, 16'h0300, 16'h0000, 5'd6, 1'b0);
        push_exp(1'b0, 5'd6, 16'h0000, 1'b0, 1'b0);
        @(negedge clk); valid_in = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 15 || mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_len: got %0d req cycles err=%b, required 15 1", n, mem_err);
        end
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (mem_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got mem_err=%b, required 1", mem_err);
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got mem_err=%b, required 0", mem_err);
        end
        // Ack in the 15th ACCESS cycle wins over the timeout.
        set_op(5'b01100, 16'h0304, 16'h0000, 5'd2, 1'b0);
        push_exp(1'b1, 5'd2, 16'h1357, 1'b1, 1'b1);
        @(negedge clk); valid_in = 1'b0;
        for (int c = 1; c < 15; c++) @(negedge clk);
        check_access("late_ack_access15", 16'h0304, 1'b0, 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h1357;
        @(negedge clk); mem_ack = 1'b0;
        checks++;
        if (mem_err !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL late_ack: got mem_err=%b wb_valid=%b, required 0 1", mem_err, wb_valid);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_timeout();
        @(negedge clk);
        set_op(5'b01100, 16'h0300, 16'h0000, 5'd6, 1'b0);
        push_exp(1'b1, 5'd6, 16'h2468, 1'b1, 1'b1);
        @(negedge clk); valid_in = 1'b0;
        for (int c = 0; c < 20; c++) @(negedge clk);
        check_access("no_timeout_wait", 16'h0300, 1'b0, 16'h0000);
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL err_tied: got mem_err=%b, required 0", mem_err);
        end
        mem_ack = 1'b1; mem_rdata = 16'h2468;
        @(negedge clk); mem_ack = 1'b0;
        check_idle("no_timeout_done");
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_abort();
        test_timeout();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_wb: got %0d retirements outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
